acc8_seq: RTL and testbench
===========================

ACC8_SEQ -- requirements
Module: acc8_seq

Interface
REQ-001 The block SHALL have one parameter, MAX_OPS (default 15): the number of operands accepted before the block reports full, legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous accumulator clear.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand on in_data is offered.
REQ-006 The block SHALL have port in_data, input, 8 bits: the unsigned operand.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand this cycle.
REQ-008 The block SHALL have port acc, output, 8 bits: the running sum.
REQ-009 The block SHALL have port ovf, output, 1 bit: sticky carry-out of bit 7.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when acc holds a newly completed sum.
REQ-011 The block SHALL have port count, output, 4 bits: the number of operands accumulated since the last reset or clear.
REQ-012 The block SHALL have port full, output, 1 bit: high when count equals MAX_OPS.

Function
REQ-013 All additions SHALL use one instance of the team's 4-bit ripple adder (ports A, B, Cin, Sum, Cout), time-shared over two cycles; no 8-bit "+" on the datapath.
REQ-014 The FSM SHALL have three states: IDLE, LO and HI.
REQ-015 In IDLE, in_ready SHALL be high when full=0 and clear=0; it SHALL be low in LO and HI.
REQ-016 An operand is accepted on an edge where in_valid=1 and in_ready=1; the block SHALL capture in_data into an operand register and go IDLE->LO.
REQ-017 In LO, the adder SHALL compute A=acc[3:0], B=op[3:0], Cin=0; on the edge, the block SHALL write acc[3:0]<=Sum, store Cout in an internal carry flop, and go LO->HI.
REQ-018 In HI, the adder SHALL compute A=acc[7:4], B=op[7:4], Cin=carry; on the edge, the block SHALL write acc[7:4]<=Sum, set ovf if Cout=1, increment count, and go HI->IDLE.
REQ-019 done SHALL be high for exactly the one cycle after the HI edge; a new handshake in that same cycle is legal.
REQ-020 Latency from the accept edge to done=1 SHALL be 2 cycles, giving a maximum throughput of one operand per 3 cycles.
REQ-021 Sums SHALL wrap modulo 256 by default, e.g. 0xF0+0x20 gives acc=0x10 and ovf=1.
REQ-022 ovf SHALL remain set until rst or clear.
REQ-023 When count reaches MAX_OPS, full SHALL be high and in_ready low until rst or clear; in_valid while full SHALL be ignored, with no state change.
REQ-024 clear=1 on any edge SHALL set acc, ovf, count and carry to 0, return the FSM to IDLE, and suppress done, aborting any operation in LO or HI.
REQ-025 If clear and in_valid are both high in one cycle, clear SHALL win and the operand SHALL NOT be accepted.
REQ-026 in_data changes after the accept edge SHALL NOT affect the result.

Reset
REQ-027 On an rst edge, the block SHALL force state=IDLE, acc=0x00, ovf=0, done=0, count=0, carry=0, and clear the operand register.
REQ-028 After rst, in_ready SHALL be high whenever clear=0.
REQ-029 rst SHALL have priority over clear and over any handshake.
REQ-030 rst asserted in LO or HI SHALL discard the partial sum, leaving no partially updated acc nibble visible after reset.

Configuration
REQ-031 The block SHALL support the macro ACC8_SAT_EN.
REQ-032 With ACC8_SAT_EN defined, a HI edge with Cout=1 SHALL write acc<=0xFF (both nibbles) and set ovf; later adds SHALL leave acc at 0xFF.
REQ-033 Without ACC8_SAT_EN, acc SHALL wrap as in REQ-021.
REQ-034 Defining ACC8_SAT_EN SHALL NOT change latency, handshake or count behaviour.

Verification
REQ-035 The bench SHALL cover: after rst, accept 0x3C then 0x45 -> done pulses 2 cycles after each accept; final acc=0x81, ovf=0, count=2.
REQ-036 The bench SHALL cover the nibble carry path: 0x0F then 0x01 -> acc=0x10, with the low-nibble carry reaching the high nibble.
REQ-037 The bench SHALL cover overflow: 0xF0 then 0x20 -> acc=0x10, ovf=1 without ACC8_SAT_EN; acc=0xFF, ovf=1 with it; a further 0x01 leaves ovf=1.
REQ-038 The bench SHALL cover fill: MAX_OPS=3 with 3 operands of 0x01 -> count=3, full=1, in_ready=0; a 4th in_valid is ignored and acc stays 0x03.
REQ-039 The bench SHALL cover clear and reset mid-operation: clear asserted in the HI cycle of 0x55 onto acc=0x22 -> next cycle acc=0x00, count=0, no done; the same stimulus with rst instead of clear gives the same result.
REQ-040 The bench SHALL cover clear priority: clear and in_valid high together -> operand not accepted, no done; plus a self-check of acc against a modulo-256 reference model over 200 random operands.

Source files
------------

// File: rtl/acc8_seq.sv
// Sequential 8-bit accumulator built on one time-shared 4-bit ripple adder.
// Optional saturation instead of wrap is enabled with the ACC8_SAT_EN macro.

module adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic c1, c2, c3;

  assign Sum[0] = A[0] ^ B[0] ^ Cin;
  assign c1     = (A[0] & B[0]) | (Cin & (A[0] ^ B[0]));
  assign Sum[1] = A[1] ^ B[1] ^ c1;
  assign c2     = (A[1] & B[1]) | (c1 & (A[1] ^ B[1]));
  assign Sum[2] = A[2] ^ B[2] ^ c2;
  assign c3     = (A[2] & B[2]) | (c2 & (A[2] ^ B[2]));
  assign Sum[3] = A[3] ^ B[3] ^ c3;
  assign Cout   = (A[3] & B[3]) | (c3 & (A[3] ^ B[3]));
endmodule

// state | meaning
// IDLE  | waiting for an operand (ready unless full or clearing)
// LO    | adding low nibbles, carry captured
// HI    | adding high nibbles with stored carry, count/ovf/done updated
module acc8_seq #(
  parameter int MAX_OPS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] acc,
  output logic       ovf,
  output logic       done,
  output logic [3:0] count,
  output logic       full
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam logic [3:0] MaxOps = 4'(MAX_OPS);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] op_q, op_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic       done_q, done_d;
  logic [3:0] count_q, count_d;

  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;

  adder4 u_add (
    .A    (add_a),
    .B    (add_b),
    .Cin  (add_cin),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  assign full     = (count_q == MaxOps);
  assign in_ready = (state_q == IDLE) && !full && !clear;
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign done     = done_q;
  assign count    = count_q;

  // Adder operand mux: low nibbles in LO, high nibbles plus carry in HI.
  always_comb begin
    add_a   = acc_q[3:0];
    add_b   = op_q[3:0];
    add_cin = 1'b0;
    if (state_q == HI) begin
      add_a   = acc_q[7:4];
      add_b   = op_q[7:4];
      add_cin = carry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = in_data;
          state_d = LO;
        end
      end
      LO: begin
        acc_d[3:0] = add_sum;
        carry_d    = add_cout;
        state_d    = HI;
      end
      HI: begin
`ifdef ACC8_SAT_EN
        acc_d = add_cout ? 8'hFF : {add_sum, acc_q[3:0]};
`else
        acc_d[7:4] = add_sum;
`endif
        if (add_cout) ovf_d = 1'b1;
        count_d = count_q + 4'd1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear aborts any in-flight add and wins over a same-cycle handshake.
    if (clear) begin
      state_d = IDLE;
      acc_d   = 8'h00;
      ovf_d   = 1'b0;
      count_d = 4'd0;
      carry_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      op_q    <= 8'h00;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_acc8_seq.sv
// Scoreboard bench for acc8_seq (MAX_OPS=3): directed scenarios plus random
// operands checked against an arithmetic reference model.

module tb_acc8_seq;
  localparam int MAX_OPS = 3;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ovf, done, full;
  logic [7:0] acc;
  logic [3:0] count;

  acc8_seq #(.MAX_OPS(MAX_OPS)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .acc      (acc),
    .ovf      (ovf),
    .done     (done),
    .count    (count),
    .full     (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] acc;
    logic       ovf;
    logic [3:0] cnt;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  // reference model state
  int   m_acc = 0;
  bit   m_ovf = 1'b0;
  int   m_cnt = 0;
  int   busy  = 0;
  int   n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a completed sum must appear exactly when due, otherwise done stays low.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("done_pulse", done, 1'b1);
        check("done_acc", acc, e.acc);
        check("done_ovf", ovf, e.ovf);
        check("done_count", count, e.cnt);
      end else begin
        check("no_spurious_done", done, 1'b0);
      end
    end
  end

  // One clock cycle: drive inputs after the falling edge, check, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    bit rdy;
    int s;
    in_valid = v;
    in_data  = d;
    clear    = c;
    rst      = r;
    #1;
    rdy = (busy == 0) && (m_cnt < MAX_OPS) && !c;
    check("in_ready", in_ready, rdy);
    if (busy == 0) begin
      check("idle_acc", acc, m_acc);
      check("idle_ovf", ovf, m_ovf);
      check("idle_count", count, m_cnt);
      check("idle_full", full, (m_cnt == MAX_OPS));
    end
    if (r || c) begin
      m_acc = 0; m_ovf = 1'b0; m_cnt = 0; busy = 0;
      sb.delete();
    end else if (busy > 0) begin
      busy--;
    end else if (v && rdy) begin
      s = m_acc + int'(d);
      if (s > 255) begin
        m_ovf = 1'b1;
`ifdef ACC8_SAT_EN
        m_acc = 255;
`else
        m_acc = s % 256;
`endif
      end else begin
        m_acc = s;
      end
      m_cnt++;
      busy = 2;
      n_acc++;
      sb.push_back('{acc: 8'(m_acc), ovf: m_ovf, cnt: 4'(m_cnt), due: cyc + 3});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic op(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    idle(2);
  endtask

  initial begin
    int  n_start;
    logic v, c, r;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); @(posedge clk); @(negedge clk);
    mon_en = 1'b1;

    // reset state, then two plain adds
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_acc", acc, 8'h00);
    op(8'h3C); op(8'h45); idle(1);
    check("sum_3c_45", acc, 8'h81);
    check("sum_ovf", ovf, 1'b0);
    check("sum_count", count, 4'd2);

    // low-nibble carry into high nibble
    step(1'b0, 8'h00, 1'b1, 1'b0);
    op(8'h0F); op(8'h01); idle(1);
    check("nibble_carry", acc, 8'h10);

    // overflow, sticky ovf
    step(1'b0, 8'h00, 1'b1, 1'b0);
    op(8'hF0); op(8'h20); idle(1);
`ifdef ACC8_SAT_EN
    check("ovf_acc", acc, 8'hFF);
`else
    check("ovf_acc", acc, 8'h10);
`endif
    check("ovf_set", ovf, 1'b1);
    op(8'h01); idle(1);
    check("ovf_sticky", ovf, 1'b1);
`ifdef ACC8_SAT_EN
    check("ovf_acc2", acc, 8'hFF);
`else
    check("ovf_acc2", acc, 8'h11);
`endif

    // fill to MAX_OPS, extra valid ignored
    step(1'b0, 8'h00, 1'b1, 1'b0);
    op(8'h01); op(8'h01); op(8'h01); idle(1);
    check("fill_count", count, 4'd3);
    check("fill_full", full, 1'b1);
    check("fill_ready", in_ready, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0); idle(3);
    check("fill_acc", acc, 8'h03);
    check("fill_count2", count, 4'd3);

    // clear in HI cycle of 0x55 onto 0x22
    step(1'b0, 8'h00, 1'b1, 1'b0);
    op(8'h22); idle(1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clear_hi_acc", acc, 8'h00);
    check("clear_hi_count", count, 4'd0);
    idle(3);

    // same with rst
    op(8'h22); idle(1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_hi_acc", acc, 8'h00);
    check("rst_hi_count", count, 4'd0);
    idle(3);

    // clear beats a same-cycle handshake
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    idle(3);
    check("clear_prio_count", count, 4'd0);
    check("clear_prio_acc", acc, 8'h00);

    // random operands against the model
    n_start = n_acc;
    for (int it = 0; it < 8000 && (n_acc - n_start) < 200; it++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ((m_cnt == MAX_OPS) && (busy == 0)) || ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, 8'($urandom), c, r);
    end
    check("random_accepts", n_acc - n_start, 200);
    idle(4);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
